// File: rtl/avalon_master_arbiter.sv
// avalon_master_arbiter
// Shares one write-master and one read-master control/data port pair between
// NUM_REQ requesters. Grants are round-robin; each grant runs one single-word
// read or write transfer, then acks the granted requester for one cycle.
//
// Build option: define ARB_TIMEOUT_EN to add a watchdog. After TIMEOUT_CYCLES
// cycles in a transfer state the transaction is closed with rsp_error=1. When
// the macro is undefined, rsp_error stays 0 and the block waits indefinitely.
//
// Handshake contract: a requester holds req_valid until it samples its
// req_ack pulse and drops it on that edge. req_valid seen high in IDLE is
// always taken as a new request. req_valid is not looked at once a grant has
// been made, so dropping it mid-transaction does not cancel the transfer.
module avalon_master_arbiter #(
    parameter int ADDRESSWIDTH    = 28,
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int NUM_REQ         = 2,
    parameter int TIMEOUT_CYCLES  = 1024,
    localparam int GW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*ADDRESSWIDTH-1:0] req_address,
    input  logic [NUM_REQ*DATAWIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic [DATAWIDTH-1:0]         rsp_rdata,
    output logic                         rsp_error,
    output logic                         busy,
    output logic [GW-1:0]                grant_id,
    output logic [2:0]                   dbg_state,

    input  logic                         write_control_done,
    output logic                         write_control_fixed_location,
    output logic [ADDRESSWIDTH-1:0]      write_control_write_base,
    output logic [ADDRESSWIDTH-1:0]      write_control_write_length,
    output logic                         write_control_go,
    output logic                         write_user_write_buffer,
    output logic [DATAWIDTH-1:0]         write_user_buffer_data,
    input  logic                         write_user_buffer_full,

    input  logic                         read_control_done,
    output logic                         read_control_fixed_location,
    output logic [ADDRESSWIDTH-1:0]      read_control_read_base,
    output logic [ADDRESSWIDTH-1:0]      read_control_read_length,
    output logic                         read_control_go,
    output logic                         read_user_read_buffer,
    input  logic [DATAWIDTH-1:0]         read_user_buffer_output_data,
    input  logic                         read_user_data_available
);

    // Low address bits that select a byte within a word; forced to 0 on the
    // base outputs so every transfer starts word-aligned.
    localparam int OFS = (BYTEENABLEWIDTH > 1) ? $clog2(BYTEENABLEWIDTH) : 0;
    localparam logic [ADDRESSWIDTH-1:0] ALIGN_MASK =
        ~((ADDRESSWIDTH'(1) << OFS) - ADDRESSWIDTH'(1));
    localparam logic [DATAWIDTH-1:0] ERR_DATA = DATAWIDTH'(32'hBAD1BAD1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_PUSH = 3'd1,
        S_WR_WAIT = 3'd2,
        S_RD_GO   = 3'd3,
        S_RD_WAIT = 3'd4,
        S_RD_POP  = 3'd5,
        S_RESP    = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           rr_q, rr_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
    logic [DATAWIDTH-1:0]    wdata_q, wdata_d;
    logic [DATAWIDTH-1:0]    rdata_q, rdata_d;
    logic                    error_q, error_d;
    // High during the first cycle of a wait state: done may still be high
    // from the previous transfer, so it is not trusted yet.
    logic                    blank_q, blank_d;

    logic                    found;
    logic [GW-1:0]           winner;
    logic [GW-1:0]           cand;
    logic [ADDRESSWIDTH-1:0] addr_sel;
    logic [DATAWIDTH-1:0]    wdata_sel;
    logic                    win_write;
    logic                    to_hit;

    // Round-robin search: first valid requester at or after the RR pointer.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = GW'((int'(rr_q) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Select the winner's address, data and direction from the packed buses.
    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        win_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == GW'(i)) begin
                addr_sel  = req_address[i*ADDRESSWIDTH +: ADDRESSWIDTH];
                wdata_sel = req_wdata[i*DATAWIDTH +: DATAWIDTH];
                win_write = req_write[i];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          counting;

    // Watchdog: held at 0 in IDLE/RESP, so it starts from 0 on entry to
    // WR_PUSH or RD_GO and counts every cycle of the transfer.
    always_comb begin
        counting = (state_q != S_IDLE) && (state_q != S_RESP);
        to_hit   = counting && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        cnt_d    = counting ? (cnt_q + CW'(1)) : '0;
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign to_hit             = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // Next-state and latched-data logic for the transaction sequencer.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;
        blank_d = blank_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = winner;
                    addr_d  = addr_sel;
                    wdata_d = wdata_sel;
                    rr_d    = (winner == GW'(NUM_REQ - 1)) ? '0 : (winner + GW'(1));
                    state_d = win_write ? S_WR_PUSH : S_RD_GO;
                end
            end
            S_WR_PUSH: begin
                if (!write_user_buffer_full) begin
                    blank_d = 1'b1;
                    state_d = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (blank_q) begin
                    blank_d = 1'b0;
                end else if (write_control_done) begin
                    error_d = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_RD_GO: begin
                blank_d = 1'b1;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (blank_q) begin
                    blank_d = 1'b0;
                end else if (read_control_done) begin
                    state_d = S_RD_POP;
                end
            end
            S_RD_POP: begin
                if (read_user_data_available) begin
                    rdata_d = read_user_buffer_output_data;
                    error_d = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A watchdog expiry overrides whatever the state would have done.
        if (to_hit) begin
            blank_d = 1'b0;
            error_d = 1'b1;
            rdata_d = ERR_DATA;
            state_d = S_RESP;
        end
    end

    // Sequencer state and latched transaction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            blank_q <= blank_d;
        end
    end

    // One-cycle ack, steered to the granted requester only.
    always_comb begin
        req_ack = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ack[i] = (state_q == S_RESP) && (grant_q == GW'(i));
        end
    end

    // Master strobes are qualified by the buffer status of the same cycle so
    // a push never lands on a full buffer and a pop never hits an empty one.
    assign write_control_go        = (state_q == S_WR_PUSH) && !write_user_buffer_full && !to_hit;
    assign write_user_write_buffer = (state_q == S_WR_PUSH) && !write_user_buffer_full && !to_hit;
    assign read_control_go         = (state_q == S_RD_GO) && !to_hit;
    assign read_user_read_buffer   = (state_q == S_RD_POP) && read_user_data_available && !to_hit;

    assign write_control_fixed_location = 1'b1;
    assign read_control_fixed_location  = 1'b1;
    assign write_control_write_length   = ADDRESSWIDTH'(BYTEENABLEWIDTH);
    assign read_control_read_length     = ADDRESSWIDTH'(BYTEENABLEWIDTH);
    assign write_control_write_base     = addr_q & ALIGN_MASK;
    assign read_control_read_base       = addr_q & ALIGN_MASK;
    assign write_user_buffer_data       = wdata_q;

    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;
    assign busy      = (state_q != S_IDLE);
    assign grant_id  = grant_q;
    assign dbg_state = state_q;

endmodule
